// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and op classification for the sequential ALU
package alu_pkg;
   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0010,
      OP_XOR  = 4'b0100,
      OP_ADD  = 4'b0110,
      OP_SUB  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_SLL  = 4'b1010,
      OP_SLT  = 4'b1101,
      OP_SLTU = 4'b1111
   } alu_op_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   function automatic logic is_shift(input logic [3:0] op);
      return op == OP_SLL || op == OP_SRL || op == OP_SRA;
   endfunction
endpackage

// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if: operand/result handshake bundle between decoder, ALU and consumer
interface alu_seq_exec_if #(parameter int WIDTH = 32);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;
   modport master (output flush, in_valid, op, a, b, out_ready,
                   input  in_ready, out_valid, result, zero, illegal);
   modport slave  (input  flush, in_valid, op, a, b, out_ready,
                   output in_ready, out_valid, result, zero, illegal);
endinterface

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: one-bit-per-cycle shifter; ALU_SEQ_FAST_SHIFT_EN swaps in a barrel shifter
module alu_seq_shifter import alu_pkg::*; #(
   parameter int WIDTH = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
`ifdef ALU_SEQ_FAST_SHIFT_EN
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   y
`else
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               load,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   y,
   output logic               last
`endif
);
`ifdef ALU_SEQ_FAST_SHIFT_EN
   logic signed [WIDTH-1:0] sra_y;
   assign sra_y = $signed(a) >>> shamt;
   assign y = op == OP_SLL ? a << shamt : op == OP_SRA ? sra_y : a >> shamt;
`else
   logic [WIDTH-1:0]   sr;
   logic [SHAMT_W-1:0] cnt;
   logic               left, arith;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr    <= '0;
         cnt   <= '0;
         left  <= 1'b0;
         arith <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (load) begin
         sr    <= a;
         cnt   <= shamt;
         left  <= op == OP_SLL;
         arith <= op == OP_SRA;
      end else if (cnt != '0) begin
         sr  <= y;
         cnt <= cnt - SHAMT_W'(1);
      end
   end
   // y is the register shifted by one more bit; the top captures it on the final step
   assign y    = left ? {sr[WIDTH-2:0], 1'b0} : {arith & sr[WIDTH-1], sr[WIDTH-1:1]};
   assign last = cnt == SHAMT_W'(1);
`endif
endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with valid/ready on both sides and iterative shifts
// Define ALU_SEQ_FAST_SHIFT_EN to make shifts single-cycle via a barrel shifter.
module alu_seq_exec import alu_pkg::*; #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   alu_seq_exec_if.slave bus
);
   localparam int SHAMT_W = $clog2(WIDTH);
   state_t             state, state_n;
   logic [WIDTH-1:0]   alu_y, sh_y, sh_now, result;
   logic [SHAMT_W-1:0] shamt;
   logic               ill, illegal, acc;
   assign shamt = bus.b[SHAMT_W-1:0];
`ifdef ALU_SEQ_FAST_SHIFT_EN
   alu_seq_shifter #(.WIDTH(WIDTH)) u_shift (.op(bus.op), .a(bus.a), .shamt, .y(sh_y));
   assign sh_now = sh_y;
`else
   logic load, fin, last;
   alu_seq_shifter #(.WIDTH(WIDTH)) u_shift (
      .clk, .rst, .flush(bus.flush), .load, .op(bus.op), .a(bus.a), .shamt, .y(sh_y), .last
   );
   // only a zero-amount shift reaches the single-cycle path
   assign sh_now = bus.a;
`endif
   always_comb begin
      alu_y = '0;
      ill   = 1'b0;
      case (bus.op)
         OP_AND:                 alu_y = bus.a & bus.b;
         OP_OR:                  alu_y = bus.a | bus.b;
         OP_XOR:                 alu_y = bus.a ^ bus.b;
         OP_ADD:                 alu_y = bus.a + bus.b;
         OP_SUB:                 alu_y = bus.a - bus.b;
         OP_SLT:                 alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLTU:                alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
         OP_SLL, OP_SRL, OP_SRA: alu_y = sh_now;
         default:                ill   = 1'b1;
      endcase
   end
   always_comb begin
      acc     = 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
      load    = 1'b0;
      fin     = 1'b0;
`endif
      state_n = state;
      if (bus.flush) state_n = IDLE;
      else case (state)
         IDLE: if (bus.in_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
            acc     = 1'b1;
            state_n = DONE;
`else
            load    = is_shift(bus.op) && shamt != '0;
            acc     = !load;
            state_n = load ? SHIFT : DONE;
`endif
         end
`ifndef ALU_SEQ_FAST_SHIFT_EN
         SHIFT: if (last) begin
            fin     = 1'b1;
            state_n = DONE;
         end
`endif
         DONE:    if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         result  <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_n;
         if (acc) begin
            result  <= alu_y;
            illegal <= ill;
         end
`ifndef ALU_SEQ_FAST_SHIFT_EN
         else if (load) illegal <= 1'b0;
         else if (fin) result <= sh_y;
`endif
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.result    = result;
   assign bus.zero      = result == '0;
   assign bus.illegal   = illegal;
endmodule
